// File: rtl/sram_port_arbiter_pkg.sv
// Shared SRAM arbiter types: FSM state enum, read tag bundle,
// SRAM bus widths and fixed read latency.
package sram_port_arbiter_pkg;

  localparam int SRAM_ADDR_W  = 18;
  localparam int SRAM_DATA_W  = 16;
  localparam int READ_LATENCY = 2;
  localparam int STARVE_CNT_W = 11;

  typedef enum logic [2:0] {
    S_ARB_IDLE  = 3'd0,
    S_ARB_M3    = 3'd1,
    S_ARB_DRAIN = 3'd2,
    S_ARB_M2    = 3'd3,
    S_ARB_TURN  = 3'd4
  } M_ARB_state_type;

  typedef struct packed {
    logic is_m2;
    logic is_m3;
  } read_tag_t;

endpackage

// File: rtl/sram_port_arbiter_read_tag_pipe.sv
// read_tag_pipe: 2-stage shift of per-cycle read tags so each
// returning SRAM word is flagged for the requester that issued it.
module read_tag_pipe
  import sram_port_arbiter_pkg::*;
(
  input  logic      CLOCK_50_I,
  input  logic      resetn,
  input  read_tag_t tag_in,
  output logic      m2_read_valid,
  output logic      m3_read_valid
);

  read_tag_t stage1;
  read_tag_t stage2;

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      stage1 <= tag_in;
      stage2 <= stage1;
    end
  end

  assign m2_read_valid = stage2.is_m2;
  assign m3_read_valid = stage2.is_m3;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the SRAM port between M2 (priority) and M3 (background
// reads); pauses M3 while M2 owns the port, routes read returns.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 1024
) (
  input  logic                   CLOCK_50_I,
  input  logic                   resetn,
  input  logic                   m2_req,
  input  logic [SRAM_ADDR_W-1:0] m2_address,
  input  logic                   m2_we_n,
  input  logic [SRAM_DATA_W-1:0] m2_write_data,
  input  logic                   m3_req,
  input  logic [SRAM_ADDR_W-1:0] m3_address,
  output logic [SRAM_ADDR_W-1:0] SRAM_address,
  output logic                   SRAM_we_n,
  output logic [SRAM_DATA_W-1:0] SRAM_write_data,
  input  logic [SRAM_DATA_W-1:0] SRAM_read_data,
  output logic [SRAM_DATA_W-1:0] read_data,
  output logic                   m2_grant,
  output logic                   m3_pause,
  output logic                   m2_read_valid,
  output logic                   m3_read_valid,
  output logic                   starve
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT =
    STARVE_CNT_W'(STARVE_LIMIT);

  M_ARB_state_type state;
  M_ARB_state_type state_n;

  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic [STARVE_CNT_W-1:0] cnt_inc;
  logic                    in_m2;
  logic                    in_m3;
  read_tag_t               tag_s0;

  assign in_m2 = (state == S_ARB_M2);
  assign in_m3 = (state == S_ARB_M3);

  always_comb begin
    state_n = state;
    unique case (state)
      S_ARB_IDLE: begin
        if (m2_req)      state_n = S_ARB_M2;
        else if (m3_req) state_n = S_ARB_M3;
      end
      S_ARB_M3: begin
        if (m2_req)       state_n = S_ARB_DRAIN;
        else if (!m3_req) state_n = S_ARB_IDLE;
      end
      // one dead cycle lets M3 see pause before M2 drives
      S_ARB_DRAIN: state_n = S_ARB_M2;
      S_ARB_M2: begin
        if (!m2_req) state_n = S_ARB_TURN;
      end
      S_ARB_TURN: begin
        if (m2_req)      state_n = S_ARB_M2;
        else if (m3_req) state_n = S_ARB_M3;
        else             state_n = S_ARB_IDLE;
      end
      default: state_n = S_ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) state <= S_ARB_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    if (in_m2) begin
      SRAM_address    = m2_address;
      SRAM_we_n       = m2_we_n;
      SRAM_write_data = m2_write_data;
    end else begin
      SRAM_address    = m3_address;
      SRAM_we_n       = 1'b1;
      SRAM_write_data = '0;
    end
  end

  assign read_data = SRAM_read_data;
  assign m2_grant  = in_m2;
  assign m3_pause  = (state == S_ARB_DRAIN) || in_m2 ||
                     (state == S_ARB_TURN);

  always_comb begin
    tag_s0       = '0;
    tag_s0.is_m2 = in_m2 && m2_we_n;
    tag_s0.is_m3 = in_m3;
  end

  read_tag_pipe u_tag_pipe (
    .CLOCK_50_I   (CLOCK_50_I),
    .resetn       (resetn),
    .tag_in       (tag_s0),
    .m2_read_valid(m2_read_valid),
    .m3_read_valid(m3_read_valid)
  );

  // saturating count of M2 cycles that kept a waiting M3 out
  assign cnt_inc = (&starve_cnt) ? starve_cnt
                                 : starve_cnt + 1'b1;

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
      starve     <= 1'b0;
    end else begin
      if (!in_m2)      starve_cnt <= '0;
      else if (m3_req) starve_cnt <= cnt_inc;
      if (in_m2 && m3_req && cnt_inc >= LIMIT)
        starve <= 1'b1;
      else if (state_n == S_ARB_M3)
        starve <= 1'b0;
    end
  end

endmodule
